// File: rtl/bin_to_bcd_x4.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding
// a four-digit seven-segment display with an overflow flag and leading-zero blanking mask.
module bin_to_bcd_x4 #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic [3:0]       blank,
    output logic             dbg_state
);

    // Handshake: start is sampled on every rising edge but is accepted (and bin
    // captured) only while busy=0; each accepted request yields exactly one done
    // pulse, and requests seen while busy=1 are dropped, not queued.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       blank_q, blank_d;
    logic             done_q, done_d;

    logic [15:0]      acc_adj;
    logic [15:0]      acc_next;

    // Digits that are not shown: leading zeros above the units digit, never on overflow.
    function automatic logic [3:0] blank_of(input logic [15:0] b, input logic o);
        logic [3:0] m;
        m[3] = (b[15:12] == 4'd0);
        m[2] = m[3] && (b[11:8] == 4'd0);
        m[1] = m[2] && (b[7:4] == 4'd0);
        m[0] = 1'b0;
        if (o) begin
            m = 4'b0000;
        end
        return m;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_adj[i*4 +: 4] = (acc_q[i*4 +: 4] >= 4'd5) ? acc_q[i*4 +: 4] + 4'd3
                                                          : acc_q[i*4 +: 4];
        end
        acc_next = {acc_adj[14:0], shift_q[WIDTH-1]};
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    acc_d      = 16'h0000;
                    ovf_pend_d = (32'(bin) > 32'd9999);
                    cnt_d      = 4'd0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = acc_next;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    bcd_d   = ovf_pend_q ? 16'h9999 : acc_next;
                    ovf_d   = ovf_pend_q;
                    blank_d = blank_of(ovf_pend_q ? 16'h9999 : acc_next, ovf_pend_q);
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            acc_q      <= 16'h0000;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            blank_q    <= 4'b1110;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
    assign blank     = blank_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_x4.sv
// Directed bench for bin_to_bcd_x4: vector table of conversions plus hand-written
// sequences for ignored start, held start, and reset during a conversion.
module tb_bin_to_bcd_x4;

    localparam int W = 14;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic [15:0]   bcd;
    logic          ovf;
    logic [3:0]    blank;
    logic          dbg_state;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // expected {bcd, ovf, blank} per accepted conversion
    logic [20:0] exp_q[$];

    typedef struct {
        int          val;
        logic [15:0] e_bcd;
        logic        e_ovf;
        logic [3:0]  e_blank;
    } vec_t;

    vec_t vecs[12];

    bin_to_bcd_x4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .ovf       (ovf),
        .blank     (blank),
        .dbg_state (dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("sb_result", 32'({bcd, ovf, blank}), 32'(e));
            end
        end
    end

    // driver: one start pulse, then cycle-exact check of busy/done/outputs
    task automatic run_conv(input int val, input logic [15:0] e_bcd, input logic e_ovf,
                            input logic [3:0] e_blank);
        logic [15:0] prev_bcd;
        @(negedge clk);
        prev_bcd = bcd;
        bin   = W'(val);
        start = 1'b1;
        exp_q.push_back({e_bcd, e_ovf, e_blank});
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (i < W) begin
                check("busy_mid", 32'(busy), 32'd1);
                check("done_mid", 32'(done), 32'd0);
                check("bcd_hold", 32'(bcd), 32'(prev_bcd));
            end else begin
                check("busy_end", 32'(busy), 32'd0);
                check("done_end", 32'(done), 32'd1);
                check("bcd", 32'(bcd), 32'(e_bcd));
                check("ovf", 32'(ovf), 32'(e_ovf));
                check("blank", 32'(blank), 32'(e_blank));
            end
        end
        @(posedge clk);
        #1 check("done_fall", 32'(done), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0]  = '{1234,  16'h1234, 1'b0, 4'b0000};
        vecs[1]  = '{7,     16'h0007, 1'b0, 4'b1110};
        vecs[2]  = '{0,     16'h0000, 1'b0, 4'b1110};
        vecs[3]  = '{9999,  16'h9999, 1'b0, 4'b0000};
        vecs[4]  = '{12000, 16'h9999, 1'b1, 4'b0000};
        vecs[5]  = '{42,    16'h0042, 1'b0, 4'b1100};
        vecs[6]  = '{10000, 16'h9999, 1'b1, 4'b0000};
        vecs[7]  = '{16383, 16'h9999, 1'b1, 4'b0000};
        vecs[8]  = '{100,   16'h0100, 1'b0, 4'b1000};
        vecs[9]  = '{10,    16'h0010, 1'b0, 4'b1100};
        vecs[10] = '{8005,  16'h8005, 1'b0, 4'b0000};
        vecs[11] = '{1000,  16'h1000, 1'b0, 4'b0000};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0000);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_blank", 32'(blank), 32'b1110);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            run_conv(vecs[k].val, vecs[k].e_bcd, vecs[k].e_ovf, vecs[k].e_blank);
        end

        // start during busy is ignored
        base = done_cnt;
        @(negedge clk);
        bin = W'(305);
        start = 1'b1;
        exp_q.push_back({16'h0305, 1'b0, 4'b1000});
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                bin = W'(8888);
                start = 1'b1;
            end else if (i == 5) begin
                start = 1'b0;
                bin = '0;
            end
            if (i == W) begin
                check("ign_done", 32'(done), 32'd1);
                check("ign_bcd", 32'(bcd), 32'h0305);
                check("ign_blank", 32'(blank), 32'b1000);
            end
        end
        repeat (20) @(posedge clk);
        #1 check("ign_one_done", 32'(done_cnt - base), 32'd1);

        // start held high: three back-to-back conversions, done every W+1 cycles
        @(negedge clk);
        bin = W'(50);
        start = 1'b1;
        repeat (3) exp_q.push_back({16'h0050, 1'b0, 4'b1100});
        @(posedge clk);
        for (int c = 1; c <= 44; c++) begin
            @(posedge clk);
            #1;
            check("held_done", 32'(done), 32'((c % 15) == 14));
            if (c >= 14) check("held_bcd", 32'(bcd), 32'h0050);
            if (c == 30) start = 1'b0;
        end
        @(posedge clk);
        #1 check("held_idle", 32'(busy), 32'd0);

        // reset aborts a conversion in flight
        @(negedge clk);
        bin = W'(4321);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h0000);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_blank", 32'(blank), 32'b1110);
        base = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_bcd_hold", 32'(bcd), 32'h0000);
        check("abort_no_done", 32'(done_cnt - base), 32'd0);

        run_conv(9, 16'h0009, 1'b0, 4'b1110);
        repeat (3) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_x4.md
# bin_to_bcd_x4

Sequential binary-to-BCD converter that feeds the four-digit seven-segment display path of the matrix multiplier. It takes an unsigned binary result element and converts it to four packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. It holds the packed value for the display's 16-bit digit input, together with an overflow flag and a leading-zero blanking mask.

## Interface
- `WIDTH`, default 14: width of the binary input. Legal range is 1..14.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. Forces reset values immediately.
- `start` input 1: conversion request. Sampled on the rising edge; accepted only while idle.
- `bin` input WIDTH: unsigned binary operand. Captured on the accepting edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse marking that `bcd`, `ovf` and `blank` have just updated.
- `bcd` output 16: packed BCD. `[15:12]` is thousands and `[3:0]` is units. Held between conversions; drives the display's 16-bit digit input.
- `ovf` output 1: high when the last captured operand exceeded 9999.
- `blank` output 4: leading-zero mask, one bit per digit (bit 3 = thousands). A 1 means the display should suppress that digit.

## Operation
- FSM states:
  - IDLE: `busy`=0. If `start`=1 at an edge, capture `bin` into the shift register, clear the BCD accumulator, compute `ovf_pending = (bin > 9999)`, clear the bit counter, go to SHIFT.
  - SHIFT: `busy`=1. Each cycle, first add 3 to every accumulator nibble that is ≥5. Then shift {accumulator, shift register} left by one and increment the counter.
  - Exit from SHIFT: the edge performing shift number WIDTH returns to IDLE and updates the outputs.
- Output update on completion:
  - `bcd` ← accumulator, or 16'h9999 if `ovf_pending`.
  - `ovf` ← `ovf_pending`.
  - `blank` recomputed from the new `bcd`.
  - `done` ← 1 for exactly one cycle.
- Overflow does not shorten the conversion. Latency is constant.
- Blank rules, computed from the registered `bcd`:
  - `blank[3]` = (d3==0).
  - `blank[2]` = `blank[3]` & (d2==0).
  - `blank[1]` = `blank[2]` & (d1==0).
  - `blank[0]` = 0 always, so a value of 0 still shows a single "0".
  - When `ovf`=1, `blank` = 4'b0000.
- `start` while `busy`=1 is ignored. No queueing, and `bin` is not re-sampled.
- `start` held high continuously restarts a new conversion on the first edge back in IDLE.
- `bcd`, `ovf` and `blank` change only on the completion edge or on reset. Intermediate accumulator values are never visible.
- Arithmetic:
  - Accumulator is 16 bits; the shift register is WIDTH bits.
  - The add-3 correction is applied per nibble, before the shift.
  - For in-range operands (≤9999), no carry leaves bit 15.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=16'h0000, `ovf`=0, `blank`=4'b1110, FSM=IDLE, counter=0.
- Let E0 be the edge at which `start` is accepted.
- `busy` rises after E0 and is high for WIDTH cycles.
- At edge E_WIDTH: `busy` falls, `done` rises, and `bcd`/`ovf`/`blank` update together. `done` falls at E_WIDTH+1.
- The earliest next accepted `start` is E_WIDTH+1. Maximum throughput is one conversion per WIDTH+1 cycles.
- With WIDTH=14: result appears 14 cycles after E0, and the next start can be accepted at E15.
- Reset asserted mid-conversion aborts immediately. All outputs take reset values and no `done` pulse is produced. After reset release, the block is idle and requires a fresh `start`.
- Reset asserted in the same cycle as `done` also clears everything. Reset has priority over all other events.

## Test plan
- Reset, then `bin`=1234 with `start` pulsed one cycle → `busy` high for 14 cycles; at E14 `bcd`=16'h1234, `ovf`=0, `blank`=4'b0000, `done` high for exactly one cycle.
- `bin`=7, then `bin`=0, then `bin`=9999 as three conversions → `bcd` 16'h0007/`blank` 4'b1110, then 16'h0000/`blank` 4'b1110, then 16'h9999/`blank` 4'b0000.
- `bin`=12000 → at E14 `bcd`=16'h9999, `ovf`=1, `blank`=4'b0000. A following conversion of 42 → `bcd`=16'h0042, `ovf`=0, `blank`=4'b1100.
- Start 0305, then pulse `start` with `bin`=8888 at E5 → second request ignored; `bcd`=16'h0305, `blank`=4'b1000; only one `done` pulse.
- `start` held high continuously with `bin`=50 → `done` pulses every 15 cycles; `bcd`=16'h0050 stable between pulses.
- Start 4321, then assert `rst` low at E7 → outputs immediately 0/0/16'h0000/0/4'b1110; no `done` pulse. After release, `bcd` stays 16'h0000 until a new `start`.
